// File: rtl/irq_encoder_8_3_if.sv
// Request/grant bus between a request source plus its consumer and the 8-to-3 IRQ encoder.
// The master side drives requests, the mask and the ack; the slave side returns the grant.
interface irq_encoder_8_3_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       overrun;

    modport master (
        output req, mask, ack,
        input  code, valid, pending, overrun
    );

    modport slave (
        input  req, mask, ack,
        output code, valid, pending, overrun
    );
endinterface

// File: rtl/irq_encoder_8_3.sv
// Registered 8-to-3 priority encoder: latches request rising edges into a pending register,
// grants the highest-priority unmasked one and holds the grant until it is acknowledged.
module irq_encoder_8_3 #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    irq_encoder_8_3_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [7:0] req_q;
    logic [7:0] pending_q;
    logic       overrun_q;

    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] elig;
    logic [2:0] sel;
    logic       valid;

    assign valid = (state_q == GRANT);
    assign rise  = bus.req & ~req_q;
    assign clr   = (valid && bus.ack) ? (8'b1 << code_q) : 8'h00;
    assign elig  = pending_q & bus.mask;

    // Later loop iterations overwrite earlier ones, so the scan order sets the priority.
    always_comb begin
        sel = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (elig[i]) sel = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (elig[i]) sel = 3'(i);
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, otherwise
    // any path that skips an assignment infers a latch.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (elig != 8'h00) begin
                    code_d  = sel;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= 3'd0;
            req_q     <= 8'h00;
            pending_q <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            req_q     <= bus.req;
            // A rise on the bit being cleared wins, so the request is not lost.
            pending_q <= (pending_q & ~clr) | rise;
            overrun_q <= |(rise & pending_q & ~clr);
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = valid;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;

endmodule

// File: doc/irq_encoder_8_3.md
# irq_encoder_8_3

Registered 8-to-3 priority encoder with request latching and a valid/ack handshake. It captures rising edges on eight request lines into a pending register and presents the index of the highest-priority unmasked pending request as a 3-bit code. It holds that code until the consumer acknowledges it, then clears the corresponding pending bit. It sits upstream of the 3-to-8 decoder path and compresses one-hot or sparse request lines into a binary index for a controller or sequencer.

## Interface
- `HIGH_FIRST`, default 1: 1 = bit 7 has highest priority; 0 = bit 0 has highest priority.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in 8: request lines, synchronous to `clk`. A 0→1 transition raises a request.
- `mask` in 8: 1 = bit eligible for encoding. Masked bits still latch into `pending`.
- `ack` in 1: consumer accepts the current `code`. Ignored while `valid`=0.
- `code` out 3: index of the granted request. Stable while `valid`=1.
- `valid` out 1: `code` is meaningful.
- `pending` out 8: current pending register.
- `overrun` out 1: one-cycle pulse when a rising edge hits a bit that is already pending.

## Operation
- Edge detect:
  - `req_q` is a registered copy of `req`.
  - `rise = req & ~req_q`.
  - On every edge, `pending <= (pending & ~clr) | rise`.
- Clear vector `clr`:
  - One-hot at `code` when `valid & ack`; otherwise 0.
  - If `rise` and `clr` hit the same bit on the same edge, the set wins: the bit stays pending.
- `overrun`:
  - Registered; asserted for one cycle when `|(rise & pending & ~clr)`.
- Eligible vector: `elig = pending & mask`.
- Priority select:
  - `HIGH_FIRST`=1: the highest set index of `elig`.
  - `HIGH_FIRST`=0: the lowest set index of `elig`.
- FSM has two states, IDLE and GRANT.
  - IDLE: `valid`=0. If `elig`≠0, register `code` ← selected index, `valid` ← 1, and go to GRANT. Otherwise stay.
  - GRANT: `valid`=1 and `code` is frozen. Later-arriving higher-priority requests, mask changes, and `req` falling do not change `code`. On `ack`=1, `valid` ← 0, the pending bit is cleared, and the FSM goes to IDLE.
  - If `mask[code]` is deasserted during GRANT, the grant still stands until `ack`.
- After an ack, the FSM always spends at least one cycle in IDLE. It never issues back-to-back grants.
- Reset values:
  - `req_q`, `pending`, `code`, `overrun` = 0.
  - `valid` = 0; FSM = IDLE.
- Asserting reset mid-grant drops `valid` immediately (asynchronous) and discards all pending requests.
  - Because `req_q` resets to 0, a `req` line held high across reset-release produces a rise on the first edge after release.

## Timing
- Request latency: if `req[k]` rises before edge E0, `pending[k]`=1 after E0. With FSM in IDLE and the bit unmasked and highest priority, `valid`=1 and `code`=k after E1. Total latency is 2 cycles.
- Ack: with `valid`=1 and `ack`=1 sampled at edge Ea, after Ea `valid`=0 and `pending[code]`=0. The earliest next `valid` is after Ea+1.
- Throughput: at most one grant every 2 cycles when `ack` is held high.
- `ack` held high while `valid`=0 has no effect.
- `pending` output reflects the register directly (0-cycle from the register).

## Test plan
- Reset and single request:
  - Stimulus: hold `rst_n`=0 with `req`=8'h00, release, `mask`=8'hFF, then raise `req[5]` before E0.
  - Required: after E1, `code`=3'd5 and `valid`=1. Ack at E2 → `valid`=0 and `pending`=8'h00 after E2.
- Priority ordering:
  - Stimulus: `HIGH_FIRST`=1, `req` 8'h00→8'h29 in one cycle, `ack` held high.
  - Required: grants in order 5, 3, 0, on alternate cycles. `valid` is low between grants.
  - Stimulus: repeat with `HIGH_FIRST`=0.
  - Required: grant order 0, 3, 5.
- Grant freeze:
  - Stimulus: `req[1]` granted (`code`=1, `valid`=1, no ack), then `req[7]` rises.
  - Required: `code` stays 1 until ack. After ack, `code`=7 two edges later.
- Masking:
  - Stimulus: `mask`=8'h0F with `req[6]` rising.
  - Required: `pending`=8'h40 and `valid` stays 0.
  - Stimulus: set `mask`=8'hFF.
  - Required: `code`=6 and `valid`=1 one edge later.
- Overrun and set-wins:
  - Stimulus: `req[2]` pulses 1-0-1 while `pending[2]`=1.
  - Required: `overrun` pulses for exactly one cycle.
  - Stimulus: a rise on `req[2]` on the same edge as ack of `code`=2.
  - Required: `pending[2]` remains 1, `overrun`=0, and `code`=2 is re-granted 1 cycle later.
- Reset mid-grant:
  - Stimulus: assert `rst_n`=0 asynchronously while `valid`=1 and `pending`=8'h81.
  - Required: `valid`, `code`, and `pending` go to 0 without waiting for a clock edge.
